keccak_squeeze: RTL and testbench
=================================

# keccak_squeeze

Output-side controller for the Keccak sponge: reads the rate portion of the 1600-bit state produced by the permutation core and streams it out as 64-bit lanes over a valid/ready handshake. When the rate is exhausted before the requested length, it requests another permutation. It sits between the Keccak-f[1600] round datapath and the Kyber samplers (SHAKE128 for matrix generation, SHAKE256 for noise and PRF output). It is the read-out counterpart of the absorb path that writes the state.

## Interface
- `RATE_LANES`, default 21. Lanes per squeeze block: 21 for SHAKE128 (168 B), 17 for SHAKE256 (136 B).
- `LEN_W`, default 16. Width of the requested-length counter, in lanes.
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `start`  in  1  One-cycle pulse that begins a squeeze. Sampled only in IDLE.
- `out_len`  in  LEN_W  Number of 64-bit lanes to emit. Sampled with `start`.
- `perm_req`  out  1  One-cycle pulse requesting one Keccak-f permutation.
- `state_valid`  in  1  One-cycle pulse from the permutation core: `state_in` holds the permuted state.
- `state_in`  in  1600  Permuted state, declared `[0:1599]`. Lane k bit z is `state_in[64*k+z]`, with k = 5y+x.
- `dout`  out  64  Output lane. `dout[z]` = lane bit z.
- `dout_valid`  out  1  `dout` is valid.
- `dout_ready`  in  1  Consumer accepts `dout`.
- `dout_last`  out  1  The current `dout` is the final lane of the squeeze.
- `busy`  out  1  High in every state except IDLE.
- `done`  out  1  One-cycle pulse after the final lane is accepted.

## Operation
- FSM states: IDLE, REQ, WAIT, STREAM.
- **IDLE**
  - `start` with `out_len`≠0: latch `remaining` = `out_len`, go to REQ.
  - `start` with `out_len`=0: pulse `done` next cycle, stay in IDLE, no `perm_req`.
- **REQ:** assert `perm_req` for exactly one cycle, then go to WAIT.
- **WAIT**
  - On `state_valid`: copy lanes 0..RATE_LANES-1 into an internal buffer, set `lane_idx`=0, go to STREAM.
  - Capacity lanes are never stored or output.
- **STREAM**
  - `dout` = buffer[`lane_idx`], with `dout_valid` high.
  - A handshake (`dout_valid`&`dout_ready`) decrements `remaining` and increments `lane_idx`.
  - Handshake with `remaining`=1: go to IDLE, pulse `done`.
  - Otherwise, handshake with `lane_idx`=RATE_LANES-1: go to REQ (next block).
- `dout_last` = `dout_valid` & (`remaining`=1).
- Ignored inputs:
  - `start` outside IDLE.
  - `state_valid` outside WAIT.
- Once a squeeze is accepted it runs until `done`; there is no abort other than reset.
- Reset at any point: return to IDLE and drop any partially streamed block.

## Timing
- Reset values: `perm_req`, `dout_valid`, `dout_last`, `busy`, `done` = 0. `dout` = 0. Buffer, `lane_idx`, `remaining` = 0.
- All outputs are registered.
- Start latency: `start` in cycle 0 → `busy` high and `perm_req` high in cycle 1.
- Block latency: `state_valid` in cycle t → `dout_valid` with lane 0 in cycle t+1.
- Throughput: one lane per cycle while `dout_ready` is held high.
- Backpressure: `dout` and `dout_last` stay stable while `dout_valid`&!`dout_ready`.
- Block boundary: handshake on the last rate lane in cycle t → `dout_valid` low and `perm_req` high in cycle t+1. Streaming resumes one cycle after the next `state_valid`.
- Completion: final handshake in cycle t → `done` high and `busy` low in cycle t+1. A new `start` is accepted in cycle t+1.
- Width: `remaining` is LEN_W bits and never underflows. `lane_idx` is ⌈log2 RATE_LANES⌉ bits and wraps to 0 only through the WAIT load.

## Configuration
- Macro: `KECCAK_SQZ_RUNTIME_RATE_EN`.
- **Defined**
  - Adds input `rate_sel` (1 bit), sampled with `start`: 0 → 21 lanes (SHAKE128), 1 → 17 lanes (SHAKE256).
  - The buffer holds 21 lanes.
  - The wrap point is set by the latched rate; `RATE_LANES` is unused.
- **Undefined**
  - No `rate_sel` port.
  - The rate is fixed at `RATE_LANES` at elaboration.

## Structure
- Shared package `keccak_pkg` holds:
  - `STATE_W`=1600, `LANE_W`=64.
  - `RATE_SHAKE128`=21, `RATE_SHAKE256`=17.
  - The squeeze FSM state enum (IDLE/REQ/WAIT/STREAM).
  - The lane-index function k = 5y+x.
- One sub-module, `keccak_lane_sel`: a combinational mux that selects buffer lane `lane_idx` onto a 64-bit bus. It is reused by the absorb-side debug readback.

## Test plan
- **Single lane:** `out_len`=1, `state_in` lane 0 = 64'h0123_4567_89AB_CDEF.
  - `perm_req` one cycle after `start`.
  - `dout`=64'h0123_4567_89AB_CDEF with `dout_last`=1 one cycle after `state_valid`.
  - `done` one cycle after the handshake.
- **Multi-block:** `out_len`=25, RATE 21, each lane k = k, `dout_ready` tied high.
  - Emits lanes 0..20, then exactly one further `perm_req`.
  - Then lanes 0..3 of the second state.
  - Exactly 2 `perm_req` pulses in total; `dout_last` only on the 25th lane.
- **Backpressure:** `dout_ready` toggles 1,0,0,1.
  - `dout` is held unchanged across stalled cycles.
  - No lane is skipped or duplicated.
- **Zero length:** `start` with `out_len`=0.
  - `done` one cycle later.
  - `perm_req`, `dout_valid`, `busy` never assert.
- **Spurious inputs:** `state_valid` asserted in IDLE, and `start` asserted during STREAM.
  - No output change from either.
  - The original squeeze completes unchanged.
- **Reset mid-stream:** `rst_n` low after 5 of 21 lanes.
  - All outputs go to 0 asynchronously.
  - A subsequent `start` restarts from REQ.

Source files
------------

// File: rtl/keccak_squeeze_pkg.sv
// Shared Keccak definitions: state/lane widths, SHAKE rates, squeeze FSM states
// and the (x,y) -> lane index mapping used by both absorb and squeeze paths.
package keccak_pkg;

    localparam int STATE_W       = 1600;
    localparam int LANE_W        = 64;
    localparam int RATE_SHAKE128 = 21;
    localparam int RATE_SHAKE256 = 17;

    typedef enum logic [1:0] {
        SQZ_IDLE,
        SQZ_REQ,
        SQZ_WAIT,
        SQZ_STREAM
    } sqz_state_e;

    function automatic int lane_index(input int x, input int y);
        return 5 * y + x;
    endfunction

endpackage

// File: rtl/keccak_squeeze_if.sv
// Squeeze-side bus: start/length request, permutation handshake and lane stream.
// rate_sel exists only when KECCAK_SQZ_RUNTIME_RATE_EN is defined.
interface keccak_squeeze_if
    import keccak_pkg::*;
#(
    parameter int LEN_W = 16
);

    logic                 start;
    logic [LEN_W-1:0]     out_len;
`ifdef KECCAK_SQZ_RUNTIME_RATE_EN
    logic                 rate_sel;
`endif
    logic                 perm_req;
    logic                 state_valid;
    logic [0:STATE_W-1]   state_in;
    logic [LANE_W-1:0]    dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 dout_last;
    logic                 busy;
    logic                 done;

    // slave is the squeeze controller, master is whoever drives it
    modport slave (
`ifdef KECCAK_SQZ_RUNTIME_RATE_EN
        input  rate_sel,
`endif
        input  start, out_len, state_valid, state_in, dout_ready,
        output perm_req, dout, dout_valid, dout_last, busy, done
    );

    modport master (
`ifdef KECCAK_SQZ_RUNTIME_RATE_EN
        output rate_sel,
`endif
        output start, out_len, state_valid, state_in, dout_ready,
        input  perm_req, dout, dout_valid, dout_last, busy, done
    );

endinterface

// File: rtl/keccak_squeeze_lane_sel.sv
// Combinational lane mux: picks lane idx out of a packed lane buffer.
// Out-of-range indices return zero.
module keccak_lane_sel
    import keccak_pkg::*;
#(
    parameter int N_LANES = 21,
    parameter int IDX_W   = 5
) (
    input  logic [N_LANES-1:0][LANE_W-1:0] lanes,
    input  logic [IDX_W-1:0]               idx,
    output logic [LANE_W-1:0]              lane
);

    always_comb begin
        lane = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (idx == IDX_W'(i)) lane = lanes[i];
        end
    end

endmodule

// File: rtl/keccak_squeeze.sv
// Keccak squeeze controller: buffers the rate lanes of each permuted state and
// streams them as 64-bit lanes. Optional KECCAK_SQZ_RUNTIME_RATE_EN adds rate_sel.
module keccak_squeeze
    import keccak_pkg::*;
#(
    parameter int RATE_LANES = 21,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    keccak_squeeze_if.slave  bus
);

`ifdef KECCAK_SQZ_RUNTIME_RATE_EN
    localparam int BUF_LANES = RATE_SHAKE128;
`else
    localparam int BUF_LANES = RATE_LANES;
`endif
    localparam int IDX_W = (BUF_LANES > 1) ? $clog2(BUF_LANES) : 1;

    sqz_state_e                        state_q, state_d;
    logic [LEN_W-1:0]                  remaining_q, remaining_d;
    logic [IDX_W-1:0]                  lane_idx_q, lane_idx_d;
    logic [BUF_LANES-1:0][LANE_W-1:0]  buf_q, buf_d;
    logic                              perm_req_q, perm_req_d;
    logic                              dout_valid_q, dout_valid_d;
    logic                              dout_last_q, dout_last_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic [LANE_W-1:0]                 dout_q, dout_d;
    logic                              load_dout;
    logic [LANE_W-1:0]                 sel_lane;
    logic [IDX_W-1:0]                  last_idx;

`ifdef KECCAK_SQZ_RUNTIME_RATE_EN
    logic [IDX_W-1:0]                  last_idx_q, last_idx_d;
    assign last_idx = last_idx_q;
`else
    assign last_idx = IDX_W'(RATE_LANES - 1);
`endif

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        lane_idx_d   = lane_idx_q;
        buf_d        = buf_q;
        perm_req_d   = 1'b0;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load_dout    = 1'b0;
`ifdef KECCAK_SQZ_RUNTIME_RATE_EN
        last_idx_d   = last_idx_q;
`endif
        case (state_q)
            SQZ_IDLE: begin
                if (bus.start) begin
                    if (bus.out_len != '0) begin
                        remaining_d = bus.out_len;
                        state_d     = SQZ_REQ;
                        perm_req_d  = 1'b1;
                        busy_d      = 1'b1;
`ifdef KECCAK_SQZ_RUNTIME_RATE_EN
                        last_idx_d  = bus.rate_sel ? IDX_W'(RATE_SHAKE256 - 1)
                                                   : IDX_W'(RATE_SHAKE128 - 1);
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SQZ_REQ: begin
                state_d = SQZ_WAIT;
            end
            SQZ_WAIT: begin
                if (bus.state_valid) begin
                    // capacity lanes (beyond the active rate) are never captured
                    for (int y = 0; y < 5; y++) begin
                        for (int x = 0; x < 5; x++) begin
                            if (lane_index(x, y) < BUF_LANES) begin
                                for (int z = 0; z < LANE_W; z++) begin
                                    buf_d[lane_index(x, y)][z] =
                                        (IDX_W'(lane_index(x, y)) <= last_idx) &&
                                        bus.state_in[LANE_W * lane_index(x, y) + z];
                                end
                            end
                        end
                    end
                    lane_idx_d   = '0;
                    state_d      = SQZ_STREAM;
                    dout_valid_d = 1'b1;
                    dout_last_d  = (remaining_q == LEN_W'(1));
                    load_dout    = 1'b1;
                end
            end
            SQZ_STREAM: begin
                if (dout_valid_q && bus.dout_ready) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    lane_idx_d  = lane_idx_q + IDX_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d      = SQZ_IDLE;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                        dout_valid_d = 1'b0;
                        dout_last_d  = 1'b0;
                    end else if (lane_idx_q == last_idx) begin
                        state_d      = SQZ_REQ;
                        perm_req_d   = 1'b1;
                        dout_valid_d = 1'b0;
                        dout_last_d  = 1'b0;
                    end else begin
                        dout_last_d  = (remaining_d == LEN_W'(1));
                        load_dout    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SQZ_IDLE;
            end
        endcase
    end

    // Registered dout looks ahead at the next buffer/index so lane 0 appears
    // one cycle after state_valid.
    keccak_lane_sel #(
        .N_LANES (BUF_LANES),
        .IDX_W   (IDX_W)
    ) u_lane_sel (
        .lanes (buf_d),
        .idx   (lane_idx_d),
        .lane  (sel_lane)
    );

    always_comb begin
        dout_d = dout_q;
        if (load_dout) dout_d = sel_lane;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SQZ_IDLE;
            remaining_q  <= '0;
            lane_idx_q   <= '0;
            buf_q        <= '0;
            perm_req_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dout_q       <= '0;
`ifdef KECCAK_SQZ_RUNTIME_RATE_EN
            last_idx_q   <= IDX_W'(RATE_SHAKE128 - 1);
`endif
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            lane_idx_q   <= lane_idx_d;
            buf_q        <= buf_d;
            perm_req_q   <= perm_req_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dout_q       <= dout_d;
`ifdef KECCAK_SQZ_RUNTIME_RATE_EN
            last_idx_q   <= last_idx_d;
`endif
        end
    end

    assign bus.perm_req   = perm_req_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_last  = dout_last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed bench for keccak_squeeze: a lane-queue model predicts every emitted
// lane, plus literal timing/value pins for single-lane, zero-length and reset cases.
module tb_keccak_squeeze;
    import keccak_pkg::*;

    localparam int RATE     = 21;
    localparam int PERM_LAT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    keccak_squeeze_if #(.LEN_W(16)) bus ();

    keccak_squeeze #(
        .RATE_LANES (RATE),
        .LEN_W      (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          pattern = 0;
    int          blk = 0;
    int          perm_cnt = 0, done_cnt = 0, hs_cnt = 0, last_hs_cnt = 0;
    bit          resp_en = 1'b1;
    bit          ready_mode = 1'b0;
    int          rdy_phase = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_dout = '0;

    // Lane content for block b, lane k; capacity lanes carry a marker that must never appear.
    function automatic logic [63:0] lane_value(input int pat, input int b, input int k);
        if (k >= RATE) return {32'hDEAD_BEEF, 32'(k)};
        case (pat)
            0:       return {32'(b), 32'(k)};
            1:       return (b == 0 && k == 0) ? 64'h0123_4567_89AB_CDEF
                                               : {32'hA5A5_0000, 32'(b * 100 + k)};
            default: return {16'hC0DE, 16'(b), 16'(k), 16'h5A5A};
        endcase
    endfunction

    function automatic logic [0:1599] make_state(input int pat, input int b);
        logic [0:1599] s;
        logic [63:0]   v;
        s = '0;
        for (int k = 0; k < 25; k++) begin
            v = lane_value(pat, b, k);
            for (int z = 0; z < 64; z++) s[64 * k + z] = v[z];
        end
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h", name, act, req);
        end
    endtask

    task automatic pulseStart(input int len);
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.out_len = 16'(len);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
    endtask

    task automatic applyStimulus(input int len, input int pat);
        pattern     = pat;
        blk         = 0;
        perm_cnt    = 0;
        done_cnt    = 0;
        hs_cnt      = 0;
        last_hs_cnt = 0;
        for (int i = 0; i < len; i++) exp_q.push_back(lane_value(pat, i / RATE, i % RATE));
        pulseStart(len);
    endtask

    task automatic waitDone(input int bound);
        int n = 0;
        while (bus.done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_timeout", 64'(n < bound), 64'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_perm_req"},   64'(bus.perm_req),   64'd0);
        checkOutput({tag, "_dout_valid"}, 64'(bus.dout_valid), 64'd0);
        checkOutput({tag, "_dout_last"},  64'(bus.dout_last),  64'd0);
        checkOutput({tag, "_busy"},       64'(bus.busy),       64'd0);
        checkOutput({tag, "_done"},       64'(bus.done),       64'd0);
        checkOutput({tag, "_dout"},       bus.dout,            64'd0);
    endtask

    // Permutation core stand-in: answers each perm_req after PERM_LAT cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.perm_req && resp_en) begin
                repeat (PERM_LAT) @(posedge clk);
                #1;
                bus.state_in    = make_state(pattern, blk);
                bus.state_valid = 1'b1;
                @(posedge clk);
                #1;
                bus.state_valid = 1'b0;
                blk++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                bus.dout_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
                rdy_phase++;
            end else begin
                bus.dout_ready = 1'b1;
            end
        end
    end

    // Model update at the clock edge: retire accepted lanes, count pulses.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (bus.perm_req) perm_cnt++;
                if (bus.done) done_cnt++;
                if (bus.dout_valid && bus.dout_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    hs_cnt++;
                    if (bus.dout_last) last_hs_cnt++;
                end
            end
        end
    end

    // Compare process: every presented lane against the model head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.dout_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL spurious_valid got dout_valid=1 dout=%h want no lane", bus.dout);
                    end else begin
                        checkOutput("dout", bus.dout, exp_q[0]);
                        checkOutput("dout_last", 64'(bus.dout_last), 64'(exp_q.size() == 1));
                    end
                    if (prev_stall) checkOutput("stall_hold", bus.dout, prev_dout);
                end else if (prev_stall) begin
                    checkOutput("stall_drop", 64'(bus.dout_valid), 64'd1);
                end
                prev_stall = bus.dout_valid && !bus.dout_ready;
                prev_dout  = bus.dout;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        bus.start       = 1'b0;
        bus.out_len     = '0;
        bus.state_valid = 1'b0;
        bus.state_in    = '0;
        bus.dout_ready  = 1'b1;
`ifdef KECCAK_SQZ_RUNTIME_RATE_EN
        bus.rate_sel    = 1'b0;
`endif
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single lane");
        applyStimulus(1, 1);
        @(negedge clk);
        checkOutput("single_perm_req", 64'(bus.perm_req), 64'd1);
        checkOutput("single_busy", 64'(bus.busy), 64'd1);
        n = 0;
        while (bus.state_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("single_sv_timeout", 64'(n < 20), 64'd1);
        @(negedge clk);
        checkOutput("single_dout_valid", 64'(bus.dout_valid), 64'd1);
        checkOutput("single_dout", bus.dout, 64'h0123_4567_89AB_CDEF);
        checkOutput("single_dout_last", 64'(bus.dout_last), 64'd1);
        @(negedge clk);
        checkOutput("single_done", 64'(bus.done), 64'd1);
        checkOutput("single_busy_low", 64'(bus.busy), 64'd0);
        @(negedge clk);
        checkOutput("single_done_pulse", 64'(bus.done), 64'd0);

        $display("[TB] multi block");
        applyStimulus(25, 0);
        waitDone(300);
        @(negedge clk);
        checkOutput("multi_perm_cnt", 64'(perm_cnt), 64'd2);
        checkOutput("multi_lanes", 64'(hs_cnt), 64'd25);
        checkOutput("multi_last_cnt", 64'(last_hs_cnt), 64'd1);
        checkOutput("multi_done_cnt", 64'(done_cnt), 64'd1);
        checkOutput("multi_queue_left", 64'(exp_q.size()), 64'd0);

        $display("[TB] backpressure");
        rdy_phase  = 0;
        ready_mode = 1'b1;
        applyStimulus(8, 2);
        waitDone(300);
        @(negedge clk);
        ready_mode = 1'b0;
        checkOutput("bp_lanes", 64'(hs_cnt), 64'd8);
        checkOutput("bp_queue_left", 64'(exp_q.size()), 64'd0);

        $display("[TB] zero length");
        applyStimulus(0, 2);
        @(negedge clk);
        checkOutput("zero_done", 64'(bus.done), 64'd1);
        checkOutput("zero_busy", 64'(bus.busy), 64'd0);
        checkOutput("zero_perm_req", 64'(bus.perm_req), 64'd0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("zero_quiet", 64'(bus.perm_req | bus.dout_valid | bus.busy), 64'd0);
        end

        $display("[TB] spurious inputs");
        @(posedge clk);
        #1;
        bus.state_in    = make_state(2, 7);
        bus.state_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.state_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_sv_valid", 64'(bus.dout_valid), 64'd0);
            checkOutput("idle_sv_busy", 64'(bus.busy), 64'd0);
        end
        applyStimulus(10, 2);
        n = 0;
        while (bus.dout_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("spur_stream_timeout", 64'(n < 30), 64'd1);
        pulseStart(3);
        waitDone(300);
        @(negedge clk);
        checkOutput("spur_lanes", 64'(hs_cnt), 64'd10);
        checkOutput("spur_perm_cnt", 64'(perm_cnt), 64'd1);
        checkOutput("spur_queue_left", 64'(exp_q.size()), 64'd0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("spur_idle_after", 64'(bus.busy), 64'd0);
        end

        $display("[TB] reset mid-stream");
        applyStimulus(21, 2);
        n = 0;
        while (hs_cnt < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst_hs_timeout", 64'(n < 100), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        checkAllZero("midrst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2, 0);
        @(negedge clk);
        checkOutput("restart_perm_req", 64'(bus.perm_req), 64'd1);
        checkOutput("restart_busy", 64'(bus.busy), 64'd1);
        waitDone(100);
        @(negedge clk);
        checkOutput("restart_lanes", 64'(hs_cnt), 64'd2);
        checkOutput("restart_perm_cnt", 64'(perm_cnt), 64'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
